// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory-side signal bundle for dmem_arbiter
// master: requesters plus the memory device; slave: the arbiter itself.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          Req0;
  logic          We0;
  logic [AW-1:0] Addr0;
  logic [DW-1:0] Wdata0;
  logic          Ack0;
  logic          Err0;
  logic [DW-1:0] Rdata0;

  logic          Req1;
  logic          We1;
  logic [AW-1:0] Addr1;
  logic [DW-1:0] Wdata1;
  logic          Ack1;
  logic          Err1;
  logic [DW-1:0] Rdata1;

  logic [AW-1:0] Mem_address;
  logic [DW-1:0] Mem_write_data;
  logic          Mem_read;
  logic          Mem_write;
  logic [DW-1:0] Mem_read_data;

  modport master (
    output Req0, We0, Addr0, Wdata0,
    input  Ack0, Err0, Rdata0,
    output Req1, We1, Addr1, Wdata1,
    input  Ack1, Err1, Rdata1,
    input  Mem_address, Mem_write_data, Mem_read, Mem_write,
    output Mem_read_data
  );

  modport slave (
    input  Req0, We0, Addr0, Wdata0,
    output Ack0, Err0, Rdata0,
    input  Req1, We1, Addr1, Wdata1,
    output Ack1, Err1, Rdata1,
    output Mem_address, Mem_write_data, Mem_read, Mem_write,
    input  Mem_read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter for the single-port data memory
// Each grant becomes one Mem_read/Mem_write strobe; out-of-range addresses never reach memory.
module dmem_arbiter #(
  parameter int MEM_DEPTH = 1000,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input logic           Clk,
  input logic           Rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RDATA, REJECT} state_t;

  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(MEM_DEPTH);

  state_t        state;
  state_t        state_nxt;

  logic          gnt;
  logic          gnt_nxt;
  logic          last_grant;
  logic          take;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  logic          done;
  logic          err;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration only happens in IDLE; on a tie the port that did not win last time goes.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    take      = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (state)
      IDLE: begin
        if (bus.Req0 && (!bus.Req1 || last_grant)) begin
          take    = 1'b1;
          gnt_nxt = 1'b0;
        end else if (bus.Req1) begin
          take    = 1'b1;
          gnt_nxt = 1'b1;
        end
        sel_we    = gnt_nxt ? bus.We1    : bus.We0;
        sel_addr  = gnt_nxt ? bus.Addr1  : bus.Addr0;
        sel_wdata = gnt_nxt ? bus.Wdata1 : bus.Wdata0;
        if (take) begin
          if ({1'b0, sel_addr} >= DEPTH_LIM) begin
            state_nxt = REJECT;
          end else if (sel_we) begin
            state_nxt = WRITE;
          end else begin
            state_nxt = READ;
          end
        end
      end
      READ:    state_nxt = RDATA;
      WRITE,
      RDATA,
      REJECT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      if (take) begin
        gnt        <= gnt_nxt;
        last_grant <= gnt_nxt;
        we_q       <= sel_we;
        addr_q     <= sel_addr;
        wdata_q    <= sel_wdata;
      end
      if (state == RDATA) begin
        if (gnt) begin
          rdata1_q <= bus.Mem_read_data;
        end else begin
          rdata0_q <= bus.Mem_read_data;
        end
      end else if (state == REJECT && !we_q) begin
        if (gnt) begin
          rdata1_q <= '0;
        end else begin
          rdata0_q <= '0;
        end
      end
    end
  end

  // Strobes depend only on state and latched values, so port inputs cannot disturb them.
  always_comb begin
    bus.Mem_read       = 1'b0;
    bus.Mem_write      = 1'b0;
    bus.Mem_address    = '0;
    bus.Mem_write_data = '0;
    done               = 1'b0;
    err                = 1'b0;
    case (state)
      WRITE: begin
        bus.Mem_write      = 1'b1;
        bus.Mem_address    = addr_q;
        bus.Mem_write_data = wdata_q;
        done               = 1'b1;
      end
      READ: begin
        bus.Mem_read    = 1'b1;
        bus.Mem_address = addr_q;
      end
      RDATA:  done = 1'b1;
      REJECT: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase

    bus.Ack0 = done && !gnt;
    bus.Ack1 = done && gnt;
    bus.Err0 = err && !gnt;
    bus.Err1 = err && gnt;

    // Bypass lets read data appear with Ack; the register holds it afterwards.
    bus.Rdata0 = rdata0_q;
    bus.Rdata1 = rdata1_q;
    if (state == RDATA) begin
      if (gnt) begin
        bus.Rdata1 = bus.Mem_read_data;
      end else begin
        bus.Rdata0 = bus.Mem_read_data;
      end
    end else if (state == REJECT && !we_q) begin
      if (gnt) begin
        bus.Rdata1 = '0;
      end else begin
        bus.Rdata0 = '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector bench for dmem_arbiter with a word memory model
module tb_dmem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1000;

  typedef struct {
    logic        req0;
    logic        we0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    int          exp_port;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.MEM_DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [0:1023];

  always @(posedge clk) begin
    if (bus.Mem_write) mem[bus.Mem_address[9:0]] <= bus.Mem_write_data;
    if (bus.Mem_read)  bus.Mem_read_data <= mem[bus.Mem_address[9:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                              input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                              input int port, input logic e, input logic [31:0] rd, input int lat);
    vec_t v;
    v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
    v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
    v.exp_port = port; v.exp_err = e; v.exp_rdata = rd; v.exp_lat = lat;
    return v;
  endfunction

  task automatic drop_reqs();
    bus.Req0 = 1'b0; bus.We0 = 1'b0; bus.Addr0 = '0; bus.Wdata0 = '0;
    bus.Req1 = 1'b0; bus.We1 = 1'b0; bus.Addr1 = '0; bus.Wdata1 = '0;
  endtask

  // Called at a negedge with the arbiter in IDLE; returns at a negedge with it in IDLE again.
  task automatic do_txn(input int idx, input vec_t v);
    logic [31:0] other_before;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rdata   = '0;
    logic        we, err = 1'b0;
    logic [31:0] addr, wdata;
    bit          got = 0, conflict = 0, strobe = 0, both_ack = 0;
    int          lat = 1, port = -1;
    string       tag;
    tag   = $sformatf("vec%0d", idx);
    we    = (v.exp_port == 1) ? v.we1    : v.we0;
    addr  = (v.exp_port == 1) ? v.addr1  : v.addr0;
    wdata = (v.exp_port == 1) ? v.wdata1 : v.wdata0;
    other_before = (v.exp_port == 1) ? bus.Rdata0 : bus.Rdata1;
    bus.Req0 = v.req0; bus.We0 = v.we0; bus.Addr0 = v.addr0; bus.Wdata0 = v.wdata0;
    bus.Req1 = v.req1; bus.We1 = v.we1; bus.Addr1 = v.addr1; bus.Wdata1 = v.wdata1;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      lat++;
      if (bus.Mem_read && bus.Mem_write) conflict = 1;
      if (bus.Mem_read || bus.Mem_write) strobe = 1;
      if (bus.Mem_write) begin
        wr_addr = bus.Mem_address;
        wr_data = bus.Mem_write_data;
      end
      if (bus.Ack0 || bus.Ack1) begin
        got      = 1;
        both_ack = bus.Ack0 && bus.Ack1;
        port     = bus.Ack1 ? 1 : 0;
        err      = bus.Ack1 ? bus.Err1 : bus.Err0;
        rdata    = bus.Ack1 ? bus.Rdata1 : bus.Rdata0;
      end
    end
    drop_reqs();
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, "_port"}, 32'(port), 32'(v.exp_port));
    check({tag, "_single_ack"}, 32'(both_ack), 32'd0);
    check({tag, "_err"}, 32'(err), 32'(v.exp_err));
    check({tag, "_strobe_conflict"}, 32'(conflict), 32'd0);
    check({tag, "_strobe_seen"}, 32'(strobe), 32'(!v.exp_err));
    if (!we) check({tag, "_rdata"}, rdata, v.exp_rdata);
    if (we && !v.exp_err) begin
      check({tag, "_wr_addr"}, wr_addr, addr);
      check({tag, "_wr_data"}, wr_data, wdata);
    end
    check({tag, "_other_rdata"}, (v.exp_port == 1) ? bus.Rdata0 : bus.Rdata1, other_before);
    @(negedge clk);
  endtask

  vec_t vecs[14];

  initial begin
    int n;
    bit got;
    vecs[0]  = mk(1, 1, 5,    32'hDEADBEEF, 0, 0, 0,    0,            0, 0, 0,            2);
    vecs[1]  = mk(1, 0, 5,    0,            0, 0, 0,    0,            0, 0, 32'hDEADBEEF, 3);
    vecs[2]  = mk(0, 0, 0,    0,            1, 1, 2,    32'hAAAA0002, 1, 0, 0,            2);
    vecs[3]  = mk(0, 0, 0,    0,            1, 0, 1000, 0,            1, 1, 0,            2);
    vecs[4]  = mk(0, 0, 0,    0,            1, 1, 1,    32'h00001234, 1, 0, 0,            2);
    vecs[5]  = mk(1, 1, 3,    32'h00005678, 0, 0, 0,    0,            0, 0, 0,            2);
    vecs[6]  = mk(0, 0, 0,    0,            1, 0, 1,    0,            1, 0, 32'h00001234, 3);
    vecs[7]  = mk(1, 0, 3,    0,            0, 0, 0,    0,            0, 0, 32'h00005678, 3);
    vecs[8]  = mk(1, 1, 7,    32'h00000077, 0, 0, 0,    0,            0, 0, 0,            2);
    vecs[9]  = mk(1, 1, 999,  32'hCAFE0999, 0, 0, 0,    0,            0, 0, 0,            2);
    vecs[10] = mk(0, 0, 0,    0,            1, 0, 999,  0,            1, 0, 32'hCAFE0999, 3);
    vecs[11] = mk(1, 1, 32'hFFFFFFFF, 32'h11111111, 0, 0, 0, 0,      0, 1, 0,            2);
    vecs[12] = mk(1, 0, 5,    0,            1, 0, 2,    0,            1, 0, 32'hAAAA0002, 3);
    vecs[13] = mk(1, 0, 1000, 0,            0, 0, 0,    0,            0, 1, 0,            2);

    rst = 1'b1;
    drop_reqs();
    @(negedge clk);
    @(negedge clk);
    check("reset_ack_err", {28'd0, bus.Ack0, bus.Ack1, bus.Err0, bus.Err1}, 32'd0);
    check("reset_rdata0", bus.Rdata0, 32'd0);
    check("reset_rdata1", bus.Rdata1, 32'd0);
    check("reset_mem_addr", bus.Mem_address, 32'd0);
    check("reset_mem_wdata", bus.Mem_write_data, 32'd0);
    check("reset_strobes", {30'd0, bus.Mem_read, bus.Mem_write}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_strobes", {30'd0, bus.Mem_read, bus.Mem_write}, 32'd0);

    for (int i = 0; i < 14; i++) do_txn(i, vecs[i]);

    // Continuous tie after reset: grants must alternate starting with port 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.Req0 = 1'b1; bus.We0 = 1'b0; bus.Addr0 = 1;
    bus.Req1 = 1'b1; bus.We1 = 1'b0; bus.Addr1 = 2;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (bus.Ack0 || bus.Ack1) begin
        check($sformatf("alt%0d_port", n), 32'(bus.Ack1), 32'(n % 2));
        check($sformatf("alt%0d_rdata", n), bus.Ack1 ? bus.Rdata1 : bus.Rdata0,
              bus.Ack1 ? 32'hAAAA0002 : 32'h00001234);
        n++;
      end
    end
    drop_reqs();
    check("alt_count", 32'(n), 32'd4);
    @(negedge clk);
    @(negedge clk);

    // Reset while READ is on the bus: strobe must fall without a clock edge.
    bus.Req0 = 1'b1; bus.We0 = 1'b0; bus.Addr0 = 5;
    @(negedge clk);
    check("rstmid_read_active", 32'(bus.Mem_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_read_dropped", 32'(bus.Mem_read), 32'd0);
    check("rstmid_addr_zero", bus.Mem_address, 32'd0);
    check("rstmid_no_ack", 32'(bus.Ack0), 32'd0);
    drop_reqs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_no_late_ack", {30'd0, bus.Ack0, bus.Ack1}, 32'd0);
    do_txn(100, mk(1, 0, 1, 0, 1, 0, 2, 0, 0, 0, 32'h00001234, 3));

    // Address change mid-READ must not move the memory access.
    bus.Req0 = 1'b1; bus.We0 = 1'b0; bus.Addr0 = 7;
    @(negedge clk);
    bus.Addr0 = 9;
    #1;
    check("addrchg_mem_addr", bus.Mem_address, 32'd7);
    check("addrchg_mem_read", 32'(bus.Mem_read), 32'd1);
    got = 0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (bus.Ack0) begin
        got = 1;
        check("addrchg_rdata", bus.Rdata0, 32'h00000077);
      end
    end
    drop_reqs();
    check("addrchg_ack_seen", 32'(got), 32'd1);
    @(negedge clk);
    check("addrchg_rdata_held", bus.Rdata0, 32'h00000077);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
